multicycle_sequencer: RTL and testbench

//  Multi-cycle FSM controller for the 16-bit CPU; sequences FETCH/DECODE/EXEC/MEM/WB per instruction.

---
 rtl/cpu_ctrl_pkg.sv | 60 ++++++
 rtl/seq_out_decode.sv | 64 ++++++
 rtl/multicycle_sequencer.sv | 137 +++++++++++++
 tb/tb_multicycle_sequencer.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the multi-cycle CPU control path.
// Contents:
//   OPW, STATEW, PCSRCW  field widths
//   OP_*                 opcode values as seen in the IR opcode field
//   PC_SRC_*             pc_src mux select encodings
//   state_e              sequencer state encodings (also the debug state output)
//   ctrl_t               bundle of datapath/memory enables from the decoder
//   uses_imm()           opcodes whose ALU operand B is the immediate
package cpu_ctrl_pkg;

    localparam int unsigned OPW    = 3;
    localparam int unsigned STATEW = 3;
    localparam int unsigned PCSRCW = 2;

    localparam logic [OPW-1:0] OP_ALU   = 3'b000;
    localparam logic [OPW-1:0] OP_ALUI  = 3'b001;
    localparam logic [OPW-1:0] OP_LOAD  = 3'b010;
    localparam logic [OPW-1:0] OP_STORE = 3'b011;
    localparam logic [OPW-1:0] OP_BEQ   = 3'b100;
    localparam logic [OPW-1:0] OP_JUMP  = 3'b101;
    localparam logic [OPW-1:0] OP_NOP   = 3'b110;
    localparam logic [OPW-1:0] OP_HALT  = 3'b111;

    localparam logic [PCSRCW-1:0] PC_SRC_INC = 2'd0;
    localparam logic [PCSRCW-1:0] PC_SRC_BR  = 2'd1;
    localparam logic [PCSRCW-1:0] PC_SRC_JMP = 2'd2;

    typedef enum logic [STATEW-1:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_HALT   = 3'd6
`ifdef SEQ_STEP_EN
        ,
        ST_PAUSE  = 3'd7
`endif
    } state_e;

    typedef struct packed {
        logic              mem_req;
        logic              mem_we;
        logic              ir_write;
        logic              pc_write;
        logic [PCSRCW-1:0] pc_src;
        logic              regwrite;
        logic              reg_dest;
        logic              aluop;
        logic              mem_to_reg;
        logic              halted;
    } ctrl_t;

    // ALU-imm, load and store all add the immediate to a register
    function automatic logic uses_imm(input logic [OPW-1:0] op);
        return (op == OP_ALUI) || (op == OP_LOAD) || (op == OP_STORE);
    endfunction

endpackage

// File: rtl/seq_out_decode.sv
// Combinational decode of sequencer state + latched opcode into enables.
// Ports:
//   state_i      current sequencer state
//   op_i         opcode latched during DECODE (used from EXEC onwards)
//   dec_op_i     live IR opcode, only consulted in DECODE for the jump
//   mem_ready_i  memory handshake completion (FETCH completion enables)
//   zero_i       ALU zero flag (branch decision in EXEC)
//   ctrl_o       bundle of all enables
module seq_out_decode
    import cpu_ctrl_pkg::*;
(
    input  state_e         state_i,
    input  logic [OPW-1:0] op_i,
    input  logic [OPW-1:0] dec_op_i,
    input  logic           mem_ready_i,
    input  logic           zero_i,
    output ctrl_t          ctrl_o
);

    // Everything idles at zero; each state raises only what it owns
    always_comb begin
        ctrl_o = '0;
        case (state_i)
            ST_FETCH: begin
                ctrl_o.mem_req = 1'b1;
                // IR and PC+1 load together on the cycle the read completes
                if (mem_ready_i) begin
                    ctrl_o.ir_write = 1'b1;
                    ctrl_o.pc_write = 1'b1;
                    ctrl_o.pc_src   = PC_SRC_INC;
                end
            end
            ST_DECODE: begin
                // The opcode is not latched yet here, so a jump is taken
                // from the IR directly to keep its CPI at 2
                if (dec_op_i == OP_JUMP) begin
                    ctrl_o.pc_write = 1'b1;
                    ctrl_o.pc_src   = PC_SRC_JMP;
                end
            end
            ST_EXEC: begin
                ctrl_o.aluop = uses_imm(op_i);
                if ((op_i == OP_BEQ) && zero_i) begin
                    ctrl_o.pc_write = 1'b1;
                    ctrl_o.pc_src   = PC_SRC_BR;
                end
            end
            ST_MEM: begin
                ctrl_o.mem_req = 1'b1;
                ctrl_o.mem_we  = (op_i == OP_STORE);
            end
            ST_WB: begin
                ctrl_o.regwrite   = 1'b1;
                ctrl_o.reg_dest   = (op_i == OP_ALUI) || (op_i == OP_LOAD);
                ctrl_o.mem_to_reg = (op_i == OP_LOAD);
            end
            ST_HALT: begin
                ctrl_o.halted = 1'b1;
            end
            default: ctrl_o = '0;
        endcase
    end

endmodule

// File: rtl/multicycle_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB control sequencer for the 16-bit CPU.
// Optional feature macro: SEQ_STEP_EN adds step_i and a PAUSE state that
// holds after each instruction until a step pulse.
// Ports:
//   clk, reset     clock and synchronous active-high reset
//   run_i          leave IDLE / keep fetching while high
//   opcode_i       IR opcode field
//   zero_i         ALU zero flag
//   mem_ready_i    memory request completes this cycle
//   step_i         (SEQ_STEP_EN only) single-step advance from PAUSE
//   mem_req_o, mem_we_o             memory request / write
//   ir_write_o, pc_write_o, pc_src_o  IR and PC load controls
//   regwrite_o, reg_dest_o, aluop_o, mem_to_reg_o  datapath controls
//   halted_o       HALT reached
//   state_o        current state (debug)
module multicycle_sequencer
    import cpu_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              run_i,
    input  logic [OPW-1:0]    opcode_i,
    input  logic              zero_i,
    input  logic              mem_ready_i,
`ifdef SEQ_STEP_EN
    input  logic              step_i,
`endif
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic              ir_write_o,
    output logic              pc_write_o,
    output logic [PCSRCW-1:0] pc_src_o,
    output logic              regwrite_o,
    output logic              reg_dest_o,
    output logic              aluop_o,
    output logic              mem_to_reg_o,
    output logic              halted_o,
    output logic [STATEW-1:0] state_o
);

    state_e         state_q, state_d;
    state_e         done_state;
    logic [OPW-1:0] op_q, op_d;
    ctrl_t          ctrl;

    // Where an instruction goes once complete; dropping run parks in IDLE
    always_comb begin
        if (!run_i) begin
            done_state = ST_IDLE;
        end else begin
`ifdef SEQ_STEP_EN
            done_state = ST_PAUSE;
`else
            done_state = ST_FETCH;
`endif
        end
    end

    // Next-state and opcode-latch logic
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        case (state_q)
            ST_IDLE: begin
                if (run_i) state_d = ST_FETCH;
            end
            ST_FETCH: begin
                if (mem_ready_i) state_d = ST_DECODE;
            end
            ST_DECODE: begin
                op_d = opcode_i;
                case (opcode_i)
                    OP_HALT:         state_d = ST_HALT;
                    OP_NOP, OP_JUMP: state_d = done_state;
                    default:         state_d = ST_EXEC;
                endcase
            end
            ST_EXEC: begin
                case (op_q)
                    OP_ALU, OP_ALUI:    state_d = ST_WB;
                    OP_LOAD, OP_STORE:  state_d = ST_MEM;
                    default:            state_d = done_state;
                endcase
            end
            ST_MEM: begin
                if (mem_ready_i) begin
                    state_d = (op_q == OP_STORE) ? done_state : ST_WB;
                end
            end
            ST_WB: begin
                state_d = done_state;
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
`ifdef SEQ_STEP_EN
            ST_PAUSE: begin
                if (step_i) state_d = ST_FETCH;
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    // State and latched-opcode registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            op_q    <= OP_ALU;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
        end
    end

    seq_out_decode u_out_decode (
        .state_i     (state_q),
        .op_i        (op_q),
        .dec_op_i    (opcode_i),
        .mem_ready_i (mem_ready_i),
        .zero_i      (zero_i),
        .ctrl_o      (ctrl)
    );

    assign mem_req_o    = ctrl.mem_req;
    assign mem_we_o     = ctrl.mem_we;
    assign ir_write_o   = ctrl.ir_write;
    assign pc_write_o   = ctrl.pc_write;
    assign pc_src_o     = ctrl.pc_src;
    assign regwrite_o   = ctrl.regwrite;
    assign reg_dest_o   = ctrl.reg_dest;
    assign aluop_o      = ctrl.aluop;
    assign mem_to_reg_o = ctrl.mem_to_reg;
    assign halted_o     = ctrl.halted;
    assign state_o      = state_q;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Self-checking bench for multicycle_sequencer: per-cycle stimulus and
// expected state/enables are queued per instruction, then replayed.
module tb_multicycle_sequencer;
    import cpu_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        run;
    logic [2:0]  opcode;
    logic        zero;
    logic        mem_ready;
    logic        step;
    logic        mem_req, mem_we, ir_write, pc_write;
    logic [1:0]  pc_src;
    logic        regwrite, reg_dest, aluop, mem_to_reg, halted;
    logic [2:0]  state;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    multicycle_sequencer dut (
        .clk          (clk),
        .reset        (reset),
        .run_i        (run),
        .opcode_i     (opcode),
        .zero_i       (zero),
        .mem_ready_i  (mem_ready),
`ifdef SEQ_STEP_EN
        .step_i       (step),
`endif
        .mem_req_o    (mem_req),
        .mem_we_o     (mem_we),
        .ir_write_o   (ir_write),
        .pc_write_o   (pc_write),
        .pc_src_o     (pc_src),
        .regwrite_o   (regwrite),
        .reg_dest_o   (reg_dest),
        .aluop_o      (aluop),
        .mem_to_reg_o (mem_to_reg),
        .halted_o     (halted),
        .state_o      (state)
    );

    logic [10:0] ctrl_obs;
    assign ctrl_obs = {mem_req, mem_we, ir_write, pc_write, pc_src,
                       regwrite, reg_dest, aluop, mem_to_reg, halted};

    typedef struct {
        string       tag;
        logic        rst;
        logic        run;
        logic        mr;
        logic        z;
        logic [2:0]  opc;
        logic [2:0]  st;
        logic [10:0] ctrl;
    } ent_t;

    ent_t sb[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [10:0] cv(input logic mreq, input logic mwe, input logic irw,
                                       input logic pcw, input logic [1:0] pcs, input logic rw,
                                       input logic rd, input logic aop, input logic m2r,
                                       input logic hlt);
        return {mreq, mwe, irw, pcw, pcs, rw, rd, aop, m2r, hlt};
    endfunction

    function automatic logic rnd();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic push(input string tag, input logic [2:0] st, input logic [10:0] c,
                        input logic r, input logic mr, input logic z,
                        input logic [2:0] opc, input logic rs);
        ent_t e;
        e.tag = tag; e.st = st; e.ctrl = c; e.run = r; e.mr = mr;
        e.z = z; e.opc = opc; e.rst = rs;
        sb.push_back(e);
    endtask

    // Expected cycles for one instruction starting in FETCH.
    // The IR value is only presented in DECODE; elsewhere it is inverted so
    // later states must rely on the latched copy.
    task automatic plan_instr(input string nm, input logic [2:0] op, input int fw,
                              input int mw, input logic z, input logic stop);
        logic r;
        logic [2:0] nop_op;
        r = ~stop;
        nop_op = ~op;
        for (int i = 0; i < fw; i++)
            push({nm, "_fwait"}, ST_FETCH, cv(1,0,0,0,2'd0,0,0,0,0,0), 1'b1, 1'b0, rnd(), nop_op, 1'b0);
        push({nm, "_fetch"}, ST_FETCH, cv(1,0,1,1,2'd0,0,0,0,0,0), 1'b1, 1'b1, rnd(), nop_op, 1'b0);
        if (op == 3'b101)
            push({nm, "_dec"}, ST_DECODE, cv(0,0,0,1,2'd2,0,0,0,0,0), r, rnd(), rnd(), op, 1'b0);
        else
            push({nm, "_dec"}, ST_DECODE, cv(0,0,0,0,2'd0,0,0,0,0,0), r, rnd(), rnd(), op, 1'b0);
        case (op)
            3'b000, 3'b001: begin
                push({nm, "_exec"}, ST_EXEC, cv(0,0,0,0,2'd0,0,0,op[0],0,0), r, rnd(), rnd(), nop_op, 1'b0);
                push({nm, "_wb"}, ST_WB, cv(0,0,0,0,2'd0,1,op[0],0,0,0), r, rnd(), rnd(), nop_op, 1'b0);
            end
            3'b010, 3'b011: begin
                push({nm, "_exec"}, ST_EXEC, cv(0,0,0,0,2'd0,0,0,1,0,0), r, rnd(), rnd(), nop_op, 1'b0);
                for (int i = 0; i < mw; i++)
                    push({nm, "_mwait"}, ST_MEM, cv(1,op[0],0,0,2'd0,0,0,0,0,0), r, 1'b0, rnd(), nop_op, 1'b0);
                push({nm, "_mem"}, ST_MEM, cv(1,op[0],0,0,2'd0,0,0,0,0,0), r, 1'b1, rnd(), nop_op, 1'b0);
                if (op == 3'b010)
                    push({nm, "_wb"}, ST_WB, cv(0,0,0,0,2'd0,1,1,0,1,0), r, rnd(), rnd(), nop_op, 1'b0);
            end
            3'b100: begin
                if (z)
                    push({nm, "_exec"}, ST_EXEC, cv(0,0,0,1,2'd1,0,0,0,0,0), r, rnd(), 1'b1, nop_op, 1'b0);
                else
                    push({nm, "_exec"}, ST_EXEC, cv(0,0,0,0,2'd0,0,0,0,0,0), r, rnd(), 1'b0, nop_op, 1'b0);
            end
            default: ;
        endcase
        if (stop) begin
            for (int i = 0; i < 3; i++)
                push({nm, "_stopidle"}, ST_IDLE, 11'd0, 1'b0, rnd(), rnd(), nop_op, 1'b0);
            push({nm, "_go"}, ST_IDLE, 11'd0, 1'b1, rnd(), rnd(), nop_op, 1'b0);
        end
    endtask

    // Replay queued cycles: drive after the rising edge, check at the falling edge
    task automatic drain();
        ent_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            reset     = e.rst;
            run       = e.run;
            mem_ready = e.mr;
            zero      = e.z;
            opcode    = e.opc;
            @(negedge clk);
            check({e.tag, "_state"}, 32'(state), 32'(e.st));
            check({e.tag, "_ctrl"}, 32'(ctrl_obs), 32'(e.ctrl));
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; run = 1'b0; opcode = 3'b000; zero = 1'b0;
        mem_ready = 1'b0; step = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        // Reset state, then remain in IDLE with run low
        for (int i = 0; i < 10; i++)
            push("idle", ST_IDLE, 11'd0, 1'b0, rnd(), rnd(), 3'b000, 1'b0);
        push("go", ST_IDLE, 11'd0, 1'b1, 1'b0, 1'b0, 3'b000, 1'b0);
        drain();

        plan_instr("alu",    3'b000, 0, 0, 1'b0, 1'b0);
        plan_instr("alui",   3'b001, 1, 0, 1'b0, 1'b0);
        plan_instr("load",   3'b010, 0, 3, 1'b0, 1'b0);
        plan_instr("store",  3'b011, 0, 0, 1'b0, 1'b0);
        plan_instr("beq_t",  3'b100, 0, 0, 1'b1, 1'b0);
        plan_instr("beq_nt", 3'b100, 2, 0, 1'b0, 1'b0);
        plan_instr("jump",   3'b101, 0, 0, 1'b0, 1'b0);
        plan_instr("nop",    3'b110, 0, 0, 1'b0, 1'b0);
        plan_instr("store2", 3'b011, 1, 2, 1'b0, 1'b0);
        plan_instr("alu_st", 3'b000, 0, 0, 1'b0, 1'b1);
        plan_instr("nop_st", 3'b110, 0, 0, 1'b0, 1'b1);
        drain();

        // Store aborted by reset while waiting in MEM
        push("rst_fetch", ST_FETCH,  cv(1,0,1,1,2'd0,0,0,0,0,0), 1'b1, 1'b1, 1'b0, 3'b100, 1'b0);
        push("rst_dec",   ST_DECODE, 11'd0,                      1'b1, 1'b0, 1'b0, 3'b011, 1'b0);
        push("rst_exec",  ST_EXEC,   cv(0,0,0,0,2'd0,0,0,1,0,0), 1'b1, 1'b0, 1'b0, 3'b100, 1'b0);
        push("rst_mwait", ST_MEM,    cv(1,1,0,0,2'd0,0,0,0,0,0), 1'b1, 1'b0, 1'b0, 3'b100, 1'b0);
        push("rst_mwait", ST_MEM,    cv(1,1,0,0,2'd0,0,0,0,0,0), 1'b1, 1'b0, 1'b0, 3'b100, 1'b0);
        push("rst_apply", ST_MEM,    cv(1,1,0,0,2'd0,0,0,0,0,0), 1'b0, 1'b0, 1'b0, 3'b100, 1'b1);
        for (int i = 0; i < 4; i++)
            push("rst_idle", ST_IDLE, 11'd0, 1'b0, rnd(), rnd(), 3'b100, 1'b0);
        push("rst_go", ST_IDLE, 11'd0, 1'b1, 1'b0, 1'b0, 3'b100, 1'b0);
        drain();

        // HALT is terminal: run and mem_ready activity must not move it
        plan_instr("halt", 3'b111, 1, 0, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++)
            push("halted", ST_HALT, cv(0,0,0,0,2'd0,0,0,0,0,1), rnd(), rnd(), rnd(), 3'($urandom_range(0, 7)), 1'b0);
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
